// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg
//
// Shared definitions for the RS-232 receive/transmit pair.
//
// Contents:
//   rx_state_t         receiver FSM state encoding (IDLE, START, DATA, STOP)
//   DATA_BITS          payload bits per frame (8N1 framing)
//   BIT_IDX_START      bit index while the start bit is on the line
//   BIT_IDX_LAST_DATA  bit index of the final data bit
//   BIT_IDX_STOP       bit index while the stop bit is on the line
//   BIT_IDX_W          width of the bit index counter
//   baud_cnt_max()     system clocks per bit, clk_freq/uart_bps (integer
//                      divide), used by both rs232_rx and rs232_tx so the
//                      two ends of the echo path always agree on bit length
// ---------------------------------------------------------------------------
package rs232_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Bit index 0 is the start bit, 1..DATA_BITS are the data bits and the
  // stop bit follows the last data bit.
  localparam int BIT_IDX_START     = 0;
  localparam int BIT_IDX_LAST_DATA = DATA_BITS;
  localparam int BIT_IDX_STOP      = DATA_BITS + 1;
  localparam int BIT_IDX_W         = 4;

  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/rs232_sync_edge.sv
// ---------------------------------------------------------------------------
// rs232_sync_edge
//
// Three-flop synchroniser for the asynchronous serial line plus a registered
// falling-edge detector used to spot the leading edge of a start bit.
// All synchroniser flops reset to 1 so a line idling high never produces a
// spurious edge out of reset.
//
// Ports:
//   clk      input   system clock, rising edge
//   rst_n    input   asynchronous active-low reset
//   rx       input   raw serial line, idle high
//   rx_sync  output  synchronised line (third flop)
//   nedge    output  one-cycle pulse, registered version of
//                    rx_reg3 & ~rx_reg2 (a high-to-low transition)
// ---------------------------------------------------------------------------
module rs232_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic nedge
);

  logic rx_reg1;
  logic rx_reg2;
  logic rx_reg3;

  // The edge flag is registered so the receiver FSM sees a clean pulse that
  // is fully decoupled from the metastability-prone first stage. Because it
  // is an edge and not a level, a line that stays low (break) cannot
  // retrigger reception on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_reg1 <= 1'b1;
      rx_reg2 <= 1'b1;
      rx_reg3 <= 1'b1;
      nedge   <= 1'b0;
    end else begin
      rx_reg1 <= rx;
      rx_reg2 <= rx_reg1;
      rx_reg3 <= rx_reg2;
      nedge   <= rx_reg3 & ~rx_reg2;
    end
  end

  assign rx_sync = rx_reg3;

endmodule

// File: rtl/rs232_rx.sv
// ---------------------------------------------------------------------------
// rs232_rx
//
// UART receiver: deserialises an asynchronous 8N1 line into bytes. Data is
// LSB first. A good frame (stop bit sampled high) updates po_data and pulses
// po_flag for one cycle; a frame whose stop bit samples low pulses po_err for
// one cycle and leaves po_data untouched. The FSM returns to IDLE at the
// stop-bit sample point, half a bit early, so back-to-back frames with a
// single stop bit are accepted.
//
// Parameters:
//   uart_bps      line baud rate (default 9600)
//   clk_freq      system_clk frequency in Hz (default 50 MHz)
//
// Ports:
//   system_clk    input      sole clock, rising edge
//   system_rst_n  input      asynchronous active-low reset
//   rx            input      serial line, idle high
//   po_data       output [7:0] last correctly received byte
//   po_flag       output     one-cycle pulse, po_data is new and valid
//   po_err        output     one-cycle pulse, framing error
//
// Build option:
//   RS232_RX_MAJORITY_EN  when defined, every bit (start, data, stop) is
//                         sampled at HALF-1, HALF and HALF+1 and decided by
//                         2-of-3 majority at HALF+1; all decisions and
//                         output pulses move one cycle later. When
//                         undefined, a single sample is taken at HALF.
// ---------------------------------------------------------------------------
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int uart_bps = 9600,
  parameter int clk_freq = 50000000
) (
  input  logic       system_clk,
  input  logic       system_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       po_err
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(clk_freq, uart_bps);
  localparam int HALF         = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

`ifdef RS232_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_EARLY0 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY1 = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);
`else
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF);
`endif

  localparam logic [BIT_IDX_W-1:0] IDX_LAST_DATA = BIT_IDX_W'(BIT_IDX_LAST_DATA);

  rx_state_t              state;
  rx_state_t              next_state;
  logic                   rx_sync;
  logic                   nedge;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   bit_val;
  logic                   decide;
  logic                   wrap;
  logic                   shift_en;
  logic                   flag_set;
  logic                   err_set;

  rs232_sync_edge u_sync_edge (
    .clk     (system_clk),
    .rst_n   (system_rst_n),
    .rx      (rx),
    .rx_sync (rx_sync),
    .nedge   (nedge)
  );

  assign decide = (cnt == CNT_DECIDE);
  assign wrap   = (cnt == CNT_LAST);

`ifdef RS232_RX_MAJORITY_EN
  logic [1:0] early;

  // The two early samples are captured in every bit period; only the one
  // taken within the current bit matters because the vote happens at
  // HALF+1 of that same bit.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      early <= 2'b11;
    end else begin
      if (cnt == CNT_EARLY0) early[0] <= rx_sync;
      if (cnt == CNT_EARLY1) early[1] <= rx_sync;
    end
  end

  assign bit_val = (early[0] & early[1]) | (early[0] & rx_sync) | (early[1] & rx_sync);
`else
  assign bit_val = rx_sync;
`endif

  // State register. Reset forces IDLE from anywhere, discarding any partial
  // byte without producing a pulse.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode. The start edge is only looked at in IDLE,
  // so edges inside a frame are ignored. A high sample mid-start-bit is a
  // glitch and aborts silently. The stop bit is left as soon as it has been
  // decided, giving half a bit of slack before the next start edge.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    flag_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (nedge) next_state = ST_START;
      end
      ST_START: begin
        if (decide && bit_val) begin
          next_state = ST_IDLE;
        end else if (wrap) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) shift_en = 1'b1;
        if (wrap && (bit_idx == IDX_LAST_DATA)) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (decide) begin
          next_state = ST_IDLE;
          if (bit_val) begin
            flag_set = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Baud counter and bit index. Both are held at zero in IDLE so that the
  // first cycle of START always begins at count 0, bit 0. Outside IDLE the
  // counter runs 0..BAUD_CNT_MAX-1 and each wrap advances the bit index.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state == ST_IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (wrap) begin
      cnt     <= '0;
      bit_idx <= bit_idx + 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  // Data bits arrive LSB first; shifting right with the new sample entering
  // at the MSB leaves the first bit in position 0 after all eight shifts.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      shift <= '0;
    end else if (shift_en) begin
      shift <= {bit_val, shift[DATA_BITS-1:1]};
    end
  end

  // Registered outputs. po_data only moves together with po_flag, so a
  // framing error leaves the previously delivered byte visible.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      po_data <= 8'h00;
      po_flag <= 1'b0;
      po_err  <= 1'b0;
    end else begin
      po_flag <= flag_set;
      po_err  <= err_set;
      if (flag_set) po_data <= shift;
    end
  end

endmodule

// File: tb/tb_rs232_rx.sv
// ---------------------------------------------------------------------------
// tb_rs232_rx
//
// Self-checking bench for rs232_rx. Frames are generated bit by bit at the
// line level; for every frame the expected outcome (good byte or framing
// error, the byte left on po_data, and the exact cycle of the pulse) is
// pushed into a scoreboard queue. An independent monitor pops an entry for
// every po_flag/po_err pulse and checks po_data against the expected value
// on every cycle. A reduced clock/baud pair keeps frames short.
// ---------------------------------------------------------------------------
module tb_rs232_rx;

  localparam int CLK_FREQ = 2000000;
  localparam int UART_BPS = 100000;
  localparam int BIT_CLKS = CLK_FREQ / UART_BPS;
  localparam int HALF_BIT = BIT_CLKS / 2;
`ifdef RS232_RX_MAJORITY_EN
  localparam int VOTE_DELAY = 1;
`else
  localparam int VOTE_DELAY = 0;
`endif
  // Cycles from the edge that first captures the start bit to the pulse.
  localparam longint PULSE_LAT = 3 + 9 * BIT_CLKS + HALF_BIT + 1 + VOTE_DELAY;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  logic       system_clk   = 1'b0;
  logic       system_rst_n = 1'b0;
  logic       rx           = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       po_err;

  exp_t       sb_q[$];
  longint     cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] mon_data  = 8'h00;

  rs232_rx #(
    .uart_bps (UART_BPS),
    .clk_freq (CLK_FREQ)
  ) dut (
    .system_clk   (system_clk),
    .system_rst_n (system_rst_n),
    .rx           (rx),
    .po_data      (po_data),
    .po_flag      (po_flag),
    .po_err       (po_err)
  );

  always #5 system_clk = ~system_clk;

  always @(posedge system_clk) cyc <= cyc + 1;

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 30)
        $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pops one scoreboard entry for the pulse currently on the outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_pulse: actual flag=%0b err=%0b at cycle %0d, required no pulse",
               po_flag, po_err, cyc);
      return;
    end
    e = sb_q.pop_front();
    checkEq("pulse_kind", {62'd0, po_flag, po_err}, {62'd0, !e.is_err, e.is_err});
    checkEq("pulse_cycle", cyc, e.cyc);
    mon_data = e.data;
  endtask

  // Monitor: one scoreboard entry per pulse, mutual exclusion of the two
  // pulses, and po_data compared with the model every cycle.
  initial begin
    forever begin
      @(negedge system_clk);
      if (!system_rst_n) begin
        mon_data = 8'h00;
      end else begin
        if (po_flag && po_err) checkEq("flag_err_exclusive", 64'd1, 64'd0);
        if (po_flag || po_err) checkOutput();
      end
      checkEq("po_data", po_data, mon_data);
    end
  end

  // Sends one 8N1 frame starting at a falling clock edge. stop_ok=0 drives
  // the stop bit low, extended by break_len further low cycles. With glitch
  // set, every data bit gets a one-cycle inverted pulse at its middle sample.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int gap,
                               input int break_len, input bit glitch);
    exp_t e;
    e.cyc    = cyc + 1 + PULSE_LAT;
    e.is_err = !stop_ok;
    if (stop_ok) last_good = b;
    e.data   = last_good;
    sb_q.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge system_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (glitch) begin
        repeat (HALF_BIT + 1) @(negedge system_clk);
        rx = ~b[i];
        @(negedge system_clk);
        rx = b[i];
        repeat (BIT_CLKS - HALF_BIT - 2) @(negedge system_clk);
      end else begin
        repeat (BIT_CLKS) @(negedge system_clk);
      end
    end
    rx = stop_ok;
    repeat (BIT_CLKS + (stop_ok ? 0 : break_len)) @(negedge system_clk);
    rx = 1'b1;
    repeat (gap) @(negedge system_clk);
  endtask

  task automatic lineGlitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge system_clk);
    rx = 1'b1;
    repeat (HALF_BIT + 10) @(negedge system_clk);
  endtask

  // Aborts a frame of 0xC3 in the middle of data bit 4 with a reset pulse.
  task automatic resetMidFrame();
    logic [7:0] v;
    v = 8'hC3;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge system_clk);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      repeat (BIT_CLKS) @(negedge system_clk);
    end
    rx = v[4];
    repeat (HALF_BIT) @(negedge system_clk);
    #2;
    system_rst_n = 1'b0;
    rx = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge system_clk);
    checkEq("midframe_reset_flag", po_flag, 1'b0);
    checkEq("midframe_reset_err", po_err, 1'b0);
    checkEq("midframe_reset_data", po_data, 8'h00);
    system_rst_n = 1'b1;
    repeat (10) @(negedge system_clk);
  endtask

  initial begin
    #(2000000);
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         gap;
    bit         gl;
    system_rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge system_clk);
    checkEq("reset_po_data", po_data, 8'h00);
    checkEq("reset_po_flag", po_flag, 1'b0);
    checkEq("reset_po_err", po_err, 1'b0);
    system_rst_n = 1'b1;
    repeat (10) @(negedge system_clk);

    $display("[TB] single frame 0x55");
    applyStimulus(8'h55, 1'b1, 5, 0, 1'b0);

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, 1'b1, 0, 0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 5, 0, 1'b0);

    $display("[TB] idle-line glitch then 0x81");
    lineGlitch(HALF_BIT - 5);
    applyStimulus(8'h81, 1'b1, 5, 0, 1'b0);

    $display("[TB] good 0x12 then 0xA5 with low stop and break");
    applyStimulus(8'h12, 1'b1, 0, 0, 1'b0);
    applyStimulus(8'hA5, 1'b0, 5, 20 * BIT_CLKS, 1'b0);

    $display("[TB] reset during frame 0xC3, then 0x3C");
    resetMidFrame();
    applyStimulus(8'h3C, 1'b1, 5, 0, 1'b0);

`ifdef RS232_RX_MAJORITY_EN
    $display("[TB] mid-bit glitches with majority voting");
    for (int n = 0; n < 8; n++) applyStimulus(8'(n), 1'b1, 0, 0, 1'b1);
    repeat (5) @(negedge system_clk);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 30; n++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? $urandom_range(0, 6) : $urandom_range(3, 8);
`ifdef RS232_RX_MAJORITY_EN
      gl  = 1'($urandom_range(0, 1));
`else
      gl  = 1'b0;
`endif
      if ($urandom_range(0, 5) == 0) lineGlitch($urandom_range(1, HALF_BIT - 5));
      applyStimulus(b, ok, gap, ok ? 0 : $urandom_range(0, 40), gl);
    end

    repeat (3 * BIT_CLKS) @(negedge system_clk);
    checkEq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
